// File: rtl/tpu_pkg.sv
// Shared sequencer types and default systolic-array geometry.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Imported by array_seq; no optional features live here.
package tpu_pkg;

    localparam int DEF_ROWS  = 4;
    localparam int DEF_COLS  = 4;
    localparam int DEF_K_MAX = 256;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        STREAM    = 3'd2,
        DRAIN     = 3'd3,
        DONE      = 3'd4
    } seq_state_t;

endpackage

// File: rtl/skew_line.sv
// 1-bit shift register with taps 0..DEPTH-1; tap i is the input delayed i cycles.
// Latency: tap 0 is combinational, tap i is i cycles. Backpressure: none, always shifts.
// Synchronous active-high reset clears every stage.
module skew_line #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [DEPTH-1:0] taps
);

    generate
        if (DEPTH > 1) begin : g_sr
            logic [DEPTH-2:0] sr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sr <= '0;
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < DEPTH - 1; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign taps = {sr, din};
        end else begin : g_wire
            assign taps = din;
        end
    endgenerate

endmodule

// File: rtl/array_seq.sv
// Systolic-array run sequencer: read-lane skews, per-diagonal valids and psum capture strobes.
// Latency: STREAM begins the cycle after both buffers hold k words; done_o at T0+k+ND+2.
// Backpressure: none once streaming; WAIT_DATA holds until operands are resident. Optional ARRAY_SEQ_PERF_CNT_EN.
module array_seq
    import tpu_pkg::*;
#(
    parameter int  ROWS  = DEF_ROWS,
    parameter int  COLS  = DEF_COLS,
    parameter int  K_MAX = DEF_K_MAX,
    localparam int KW    = $clog2(K_MAX + 1),
    localparam int ND    = ROWS + COLS - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [KW-1:0]   k_i,
    input  logic [KW-1:0]   ub_level_i,
    input  logic [KW-1:0]   wf_level_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [COLS-1:0] act_rd_o,
    output logic [ROWS-1:0] wt_rd_o,
    output logic [ND-1:0]   diag_valid_o,
    output logic [ND-1:0]   cap_diag_o
`ifdef ARRAY_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]     busy_cyc_o,
    output logic [31:0]     wait_cyc_o
`endif
);

    // At least three taps so the capture source below always has tap 2.
    localparam int RD_DEPTH = (ND + 1 > 3) ? ND + 1 : 3;
    localparam logic [KW-1:0] K_MAX_W = KW'(K_MAX);

    seq_state_t          state_q, state_d;
    logic [KW-1:0]       k_q;
    logic [KW-1:0]       cnt_q;
    logic [KW-1:0]       k_clamped;
    logic                base_rd;
    logic                last_beat;
    logic                cap_src;
    logic                cap_end;
    logic [RD_DEPTH-1:0] rd_taps;
    logic [ND:0]         cap_taps;

    assign k_clamped = (k_i > K_MAX_W) ? K_MAX_W : k_i;
    assign base_rd   = (state_q == STREAM);
    assign last_beat = base_rd && (cnt_q == k_q - KW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (k_i == '0) ? DONE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if ((ub_level_i >= k_q) && (wf_level_i >= k_q)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_beat) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cap_end) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
        end else if ((state_q == IDLE) && start_i && (k_i != '0)) begin
            k_q <= k_clamped;
        end
    end

    // Beat counter only runs during STREAM; it tops out at k-1 so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || !base_rd) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + KW'(1);
        end
    end

    skew_line #(.DEPTH(RD_DEPTH)) u_rd_skew (
        .clk  (clk),
        .rst  (rst),
        .din  (base_rd),
        .taps (rd_taps)
    );

    // Diagonal 0 valid falls at T0+k+1: that is the single cycle its psum is final.
    assign cap_src = rd_taps[2] & ~rd_taps[1];

    skew_line #(.DEPTH(ND + 1)) u_cap_skew (
        .clk  (clk),
        .rst  (rst),
        .din  (cap_src),
        .taps (cap_taps)
    );

    assign cap_end      = cap_taps[ND];
    assign act_rd_o     = rd_taps[COLS-1:0];
    assign wt_rd_o      = rd_taps[ROWS-1:0];
    assign diag_valid_o = rd_taps[ND:1];
    assign cap_diag_o   = cap_taps[ND-1:0];
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);

`ifdef ARRAY_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cyc_o <= '0;
            wait_cyc_o <= '0;
        end else begin
            if (busy_o && (busy_cyc_o != '1)) begin
                busy_cyc_o <= busy_cyc_o + 32'd1;
            end
            if ((state_q == WAIT_DATA) && (wait_cyc_o != '1)) begin
                wait_cyc_o <= wait_cyc_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/array_seq.md
ARRAY_SEQ -- requirements
Module: array_seq

Interface
- REQ-001: Parameter ROWS, default 4: PE rows in the systolic array; weights enter from the west, one lane per row.
- REQ-002: Parameter COLS, default 4: PE columns; activations enter from the north, one lane per column.
- REQ-003: Parameter K_MAX, default 256: maximum reduction length per run; KW = clog2(K_MAX+1).
- REQ-004: Localparam ND = ROWS+COLS-1: number of PE anti-diagonals, where d = r+c.
- REQ-005: Port clk, input, 1: single clock; all logic is on the rising edge.
- REQ-006: Port rst, input, 1: reset, synchronous and active-high.
- REQ-007: Port start_i, input, 1: run request; sampled only in IDLE.
- REQ-008: Port k_i, input, KW: reduction length for the run; captured when start is accepted.
- REQ-009: Port ub_level_i, input, KW: Unified Buffer words available.
- REQ-010: Port wf_level_i, input, KW: Weight FIFO words available.
- REQ-011: Port busy_o, output, 1: high in every state except IDLE.
- REQ-012: Port done_o, output, 1: one-cycle pulse at the end of a run.
- REQ-013: Port act_rd_o, output, COLS: per-column Unified Buffer read enable.
- REQ-014: Port wt_rd_o, output, ROWS: per-row Weight FIFO read enable.
- REQ-015: Port diag_valid_o, output, ND: PE valid_i, one bit per anti-diagonal.
- REQ-016: Port cap_diag_o, output, ND: psum capture strobe, one bit per anti-diagonal.

Function
- REQ-017: The FSM states SHALL be IDLE, WAIT_DATA, STREAM, DRAIN and DONE.
- REQ-018: In IDLE, start_i=1 with k_i>0 SHALL latch k, and the FSM SHALL enter WAIT_DATA on the next cycle.
- REQ-019: In IDLE, start_i=1 with k_i=0 SHALL go to DONE, with no reads, valids or captures issued.
- REQ-020: k_i>K_MAX SHALL be clamped to K_MAX.
- REQ-021: WAIT_DATA SHALL hold until ub_level_i>=k and wf_level_i>=k in the same cycle, then enter STREAM; the PEs cannot stall, so the whole operand set must be resident first.
- REQ-022: STREAM SHALL last exactly k cycles, with the first cycle defined as T0.
- REQ-023: The base read strobe SHALL be high for T0..T0+k-1.
- REQ-024: act_rd_o[j] and wt_rd_o[j] SHALL equal the base read strobe delayed j cycles.
- REQ-025: diag_valid_o[d] SHALL be high for T0+1+d through T0+k+d, contiguously; this accounts for 1-cycle buffer read latency, and any gap would clear the MAC accumulators.
- REQ-026: cap_diag_o[d] SHALL pulse for exactly one cycle at T0+k+d+1, the only cycle in which that diagonal's psum holds the final sum.
- REQ-027: The FSM SHALL move from STREAM to DRAIN after cycle T0+k-1.
- REQ-028: The FSM SHALL move from DRAIN to DONE in the cycle after cap_diag_o[ND-1] pulses.
- REQ-029: DONE SHALL last one cycle with done_o=1, then return to IDLE.
- REQ-030: start_i SHALL be ignored while busy_o=1.
- REQ-031: A start in the DONE cycle SHALL be ignored.
- REQ-032: Each act_rd_o and wt_rd_o lane SHALL assert exactly k times per run.
- REQ-033: Each cap_diag_o bit SHALL assert exactly once per run with k>0.
- REQ-034: The stream counter SHALL be KW bits and SHALL NOT wrap within a run.

Reset
- REQ-035: rst SHALL force the FSM to IDLE and clear every skew stage and counter.
- REQ-036: On the cycle after rst, all outputs SHALL be 0.
- REQ-037: Reset mid-run SHALL abort the run with no done_o and no further reads or captures.
- REQ-038: rst SHALL take priority over start_i in the same cycle.

Configuration
- REQ-039: With macro ARRAY_SEQ_PERF_CNT_EN defined, the block SHALL add output busy_cyc_o (32 bits, counts cycles with busy_o=1) and output wait_cyc_o (32 bits, counts cycles in WAIT_DATA).
- REQ-040: Both counters SHALL saturate at all-ones and SHALL be cleared only by rst.
- REQ-041: Without ARRAY_SEQ_PERF_CNT_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
- REQ-042: Shared package tpu_pkg SHALL hold the seq_state_t enum and the default ROWS, COLS and K_MAX constants.
- REQ-043: One sub-module, skew_line (parameter DEPTH, a 1-bit shift register producing taps 0..DEPTH-1, reset to 0), SHALL generate the read-lane skews.
- REQ-044: skew_line SHALL also generate the diagonal valid skew and the capture skew.

Verification (ROWS=COLS=4, ND=7)
- REQ-045: Levels at 8, start with k=8: act_rd_o[0] high for T0..T0+7; act_rd_o[3] high for T0+3..T0+10; diag_valid_o[6] high for T0+7..T0+14; cap_diag_o[0] pulses at T0+9; cap_diag_o[6] pulses at T0+15; done_o pulses at T0+17.
- REQ-046: Levels at 3, start with k=8: the FSM holds in WAIT_DATA with no reads; raising ub_level_i to 8 alone keeps the hold; raising wf_level_i to 8 starts STREAM on the next cycle.
- REQ-047: start with k=0: done_o pulses 1 cycle later; no lane, valid or capture bit toggles.
- REQ-048: Second start pulse at T0+3: it is ignored; exactly 8 reads occur per lane and one done_o.
- REQ-049: rst at T0+5: all outputs are 0 the next cycle; no done_o; a new start with k=1 then completes, with cap_diag_o[6] at T0'+8.
- REQ-050: With ARRAY_SEQ_PERF_CNT_EN, the REQ-045 run with a 2-cycle wait yields wait_cyc_o=2 and busy_cyc_o=20.
